// File: rtl/agnus_audio_pkg.sv
// agnus_audio_pkg: shared constants for the audio DMA slot scheduler
package agnus_audio_pkg;
  localparam int NCH = 4;
  localparam logic [8:0] STROBE_HPOS_DEF = 9'h001;
  localparam logic [8:0] SLOT_BASE_DEF = 9'h00D;
  localparam logic [7:0] AUDLCH = 8'h50;
  localparam logic [7:0] AUDLCL = 8'h51;
  localparam logic [7:0] AUDDAT = 8'h55;
  localparam logic [7:0] AUD_STRIDE = 8'h08;
  function automatic logic [7:0] aud_reg(input logic [7:0] base, input int n);
    return base + AUD_STRIDE * 8'(n);
  endfunction
endpackage

// File: rtl/agnus_audio_ptr.sv
// agnus_audio_ptr: location latch, running pointer and pending request for one audio channel
module agnus_audio_ptr
  import agnus_audio_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        cck,
  input  logic        sample,
  input  logic        hit,
  input  logic        dmaen,
  input  logic        dmareq,
  input  logic        dmas,
  input  logic [7:0]  reg_address_in,
  input  logic [15:0] data_in,
  output logic        active,
  output logic [19:0] address
);
  logic [19:0] lc, pt;
  logic pend, restart;
  assign active = hit & pend & dmaen;
  assign address = restart ? lc : pt;
  // latch writes, request sampling, slot completion and enable-drop cancellation
  always_ff @(posedge clk) begin
    if (reset) begin
      lc <= '0;
      pt <= '0;
      pend <= 1'b0;
      restart <= 1'b0;
    end else if (clk7_en) begin
      if (reg_address_in == aud_reg(AUDLCH, IDX)) lc[19:15] <= data_in[4:0];
      if (reg_address_in == aud_reg(AUDLCL, IDX)) lc[14:0] <= data_in[15:1];
      if (active & cck) pt <= address + 20'd1;
      if (sample) begin
        pend <= dmareq & dmaen;
        restart <= dmas;
      end else if ((active & cck) | ~dmaen) begin
        pend <= 1'b0;
        restart <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/agnus_audio_dma.sv
// agnus_audio_dma: audio DMA request sampling, slot decode and chip-bus address mux
module agnus_audio_dma
  import agnus_audio_pkg::*;
#(
  parameter logic [8:0] STROBE_HPOS = STROBE_HPOS_DEF,
  parameter logic [8:0] SLOT_BASE = SLOT_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        cck,
  input  logic [8:0]  hpos,
  input  logic [3:0]  dmaen,
  input  logic [3:0]  dmareq,
  input  logic [3:0]  dmas,
  input  logic [7:0]  reg_address_in,
  input  logic [15:0] data_in,
  output logic        strhor,
  output logic        dma,
  output logic [19:0] address_out,
  output logic [7:0]  reg_address_out
);
  logic sample;
  logic [NCH-1:0] active;
  logic [19:0] addr [NCH];
  assign sample = clk7_en & cck & (hpos == STROBE_HPOS);
  assign strhor = sample & ~reset;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    agnus_audio_ptr #(.IDX(g)) u_ptr (
      .clk(clk),
      .reset(reset),
      .clk7_en(clk7_en),
      .cck(cck),
      .sample(sample),
      .hit(hpos == SLOT_BASE + 9'(2 * g)),
      .dmaen(dmaen[g]),
      .dmareq(dmareq[g]),
      .dmas(dmas[g]),
      .reg_address_in(reg_address_in),
      .data_in(data_in),
      .active(active[g]),
      .address(addr[g])
    );
  end
  // slots are disjoint, so at most one channel drives the bus outputs
  always_comb begin
    dma = 1'b0;
    address_out = '0;
    reg_address_out = 8'hFF;
    for (int n = 0; n < NCH; n++) begin
      if (active[n]) begin
        dma = 1'b1;
        address_out = addr[n];
        reg_address_out = aud_reg(AUDDAT, n);
      end
    end
  end
endmodule

// File: tb/tb_agnus_audio_dma.sv
// tb_agnus_audio_dma: directed scoreboard bench for the audio DMA scheduler
module tb_agnus_audio_dma;
  logic clk = 1'b0;
  logic reset, clk7_en, cck;
  logic [8:0] hpos;
  logic [3:0] dmaen, dmareq, dmas;
  logic [7:0] reg_address_in;
  logic [15:0] data_in;
  logic strhor, dma;
  logic [19:0] address_out;
  logic [7:0] reg_address_out;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic dma;
    logic [19:0] addr;
    logic [7:0] regv;
    logic strhor;
  } exp_t;
  exp_t sb[$];
  logic [19:0] m_lc [4];
  logic [19:0] m_pt [4];
  logic m_pend [4];
  logic m_rst [4];
  logic obs_dma [512];
  logic [19:0] obs_addr [512];
  logic [7:0] obs_reg [512];
  logic obs_str [512];

  agnus_audio_dma dut (
    .clk(clk),
    .reset(reset),
    .clk7_en(clk7_en),
    .cck(cck),
    .hpos(hpos),
    .dmaen(dmaen),
    .dmareq(dmareq),
    .dmas(dmas),
    .reg_address_in(reg_address_in),
    .data_in(data_in),
    .strhor(strhor),
    .dma(dma),
    .address_out(address_out),
    .reg_address_out(reg_address_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [8:0] h);
    exp_t e, g;
    logic act [4];
    logic [19:0] base [4];
    hpos = h;
    e.dma = 1'b0;
    e.addr = '0;
    e.regv = 8'hFF;
    e.strhor = ~reset & (h == 9'h001);
    for (int n = 0; n < 4; n++) begin
      act[n] = (h == 9'(13 + 2 * n)) & m_pend[n] & dmaen[n];
      base[n] = m_rst[n] ? m_lc[n] : m_pt[n];
      if (act[n]) begin
        e.dma = 1'b1;
        e.addr = base[n];
        e.regv = 8'(8'h55 + 8 * n);
      end
    end
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    obs_dma[h] = dma;
    obs_addr[h] = address_out;
    obs_reg[h] = reg_address_out;
    obs_str[h] = strhor;
    chk($sformatf("dma@%h", h), 32'(dma), 32'(g.dma));
    chk($sformatf("addr@%h", h), 32'(address_out), 32'(g.addr));
    chk($sformatf("reg@%h", h), 32'(reg_address_out), 32'(g.regv));
    chk($sformatf("strhor@%h", h), 32'(strhor), 32'(g.strhor));
    for (int n = 0; n < 4; n++) begin
      if (reset) begin
        m_lc[n] = '0;
        m_pt[n] = '0;
        m_pend[n] = 1'b0;
        m_rst[n] = 1'b0;
      end else begin
        if (reg_address_in == 8'(8'h50 + 8 * n)) m_lc[n][19:15] = data_in[4:0];
        if (reg_address_in == 8'(8'h51 + 8 * n)) m_lc[n][14:0] = data_in[15:1];
        if (h == 9'h001) begin
          m_pend[n] = dmareq[n] & dmaen[n];
          m_rst[n] = dmas[n];
        end else if (act[n]) begin
          m_pt[n] = base[n] + 20'd1;
          m_pend[n] = 1'b0;
          m_rst[n] = 1'b0;
        end else if (!dmaen[n]) begin
          m_pend[n] = 1'b0;
          m_rst[n] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    reg_address_in = a;
    data_in = d;
    tick(9'h100);
    reg_address_in = 8'h00;
  endtask

  task automatic run_line(input int ev_h, input logic [3:0] en_after, input logic [7:0] wa,
                          input logic [15:0] wd, input logic rs);
    for (int h = 0; h < 24; h++) begin
      if (h == ev_h) begin
        dmaen = en_after;
        reg_address_in = wa;
        data_in = wd;
        reset = rs;
      end else if (h == ev_h + 1) begin
        reg_address_in = 8'h00;
        reset = 1'b0;
      end
      tick(9'(h));
    end
  endtask

  initial begin
    for (int n = 0; n < 4; n++) begin
      m_lc[n] = '0;
      m_pt[n] = '0;
      m_pend[n] = 1'b0;
      m_rst[n] = 1'b0;
    end
    reset = 1'b1;
    clk7_en = 1'b1;
    cck = 1'b1;
    hpos = 9'h100;
    dmaen = 4'hF;
    dmareq = 4'h0;
    dmas = 4'h0;
    reg_address_in = 8'h00;
    data_in = 16'h0000;
    @(posedge clk);
    #1;
    tick(9'h001);
    tick(9'h00D);
    reset = 1'b0;
    wr(8'h50, 16'h0001);
    wr(8'h51, 16'h2340);
    dmareq = 4'b0001;
    dmas = 4'b0001;
    run_line(-1, 4'hF, 8'h00, 16'h0, 1'b0);
    chk("strobe", 32'(obs_str[1]), 32'd1);
    chk("ch0_dma", 32'(obs_dma[13]), 32'd1);
    chk("ch0_restart_addr", 32'(obs_addr[13]), 32'h091A0);
    chk("ch0_reg", 32'(obs_reg[13]), 32'h55);
    dmas = 4'b0000;
    run_line(-1, 4'hF, 8'h00, 16'h0, 1'b0);
    chk("ch0_next_addr", 32'(obs_addr[13]), 32'h091A1);
    wr(8'h58, 16'h0002);
    wr(8'h59, 16'h0000);
    wr(8'h60, 16'h001F);
    wr(8'h61, 16'hFFFC);
    wr(8'h68, 16'h0003);
    wr(8'h69, 16'h0100);
    dmareq = 4'hF;
    dmas = 4'b1110;
    run_line(-1, 4'hF, 8'h00, 16'h0, 1'b0);
    chk("ch0_pt_lc2", 32'(obs_addr[13]), 32'h091A2);
    chk("reg_ch1", 32'(obs_reg[15]), 32'h5D);
    chk("reg_ch2", 32'(obs_reg[17]), 32'h65);
    chk("reg_ch3", 32'(obs_reg[19]), 32'h6D);
    chk("ch2_restart", 32'(obs_addr[17]), 32'hFFFFE);
    dmareq = 4'b0100;
    dmas = 4'b0000;
    run_line(-1, 4'hF, 8'h00, 16'h0, 1'b0);
    chk("ch2_top", 32'(obs_addr[17]), 32'hFFFFF);
    run_line(-1, 4'hF, 8'h00, 16'h0, 1'b0);
    chk("ch2_wrap", 32'(obs_addr[17]), 32'h00000);
    dmareq = 4'b0010;
    run_line(5, 4'b1101, 8'h00, 16'h0, 1'b0);
    chk("ch1_dropped", 32'(obs_dma[15]), 32'd0);
    dmaen = 4'hF;
    run_line(-1, 4'hF, 8'h00, 16'h0, 1'b0);
    chk("ch1_pt_kept", 32'(obs_addr[15]), 32'h10001);
    dmareq = 4'b1000;
    dmas = 4'b1000;
    run_line(19, 4'hF, 8'h69, 16'h0200, 1'b0);
    chk("ch3_old_lc", 32'(obs_addr[19]), 32'h18080);
    run_line(-1, 4'hF, 8'h00, 16'h0, 1'b0);
    chk("ch3_new_lc", 32'(obs_addr[19]), 32'h18100);
    dmareq = 4'hF;
    dmas = 4'h0;
    run_line(15, 4'hF, 8'h00, 16'h0, 1'b1);
    chk("rst_dma", 32'(obs_dma[17]), 32'd0);
    chk("rst_addr", 32'(obs_addr[17]), 32'd0);
    chk("rst_reg", 32'(obs_reg[17]), 32'hFF);
    dmas = 4'hF;
    run_line(-1, 4'hF, 8'h00, 16'h0, 1'b0);
    chk("post_rst_dma", 32'(obs_dma[13]), 32'd1);
    chk("post_rst_lc", 32'(obs_addr[13]), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/agnus_audio_dma.md
# agnus_audio_dma

Audio DMA slot scheduler and address generator for the four Paula audio channels. Samples the channels' DMA requests once per scanline, issues the horizontal strobe that clears them, and converts each pending request into one chip-bus access in that channel's fixed audio slot. Owns the AUDxLC location latches and the running AUDxPT pointers. Sits in Agnus between the four audio channels and the chip-bus slot mux.

## Interface
Parameters:
- STROBE_HPOS, 9'h001, hpos at which requests are sampled and strhor pulses
- SLOT_BASE, 9'h00D, hpos of channel 0 slot; channel n slot = SLOT_BASE + 2n

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clk7_en  in  1  clock enable; all state changes qualified by it
- cck  in  1  colour clock enable
- hpos  in  9  current horizontal beam position
- dmaen  in  4  per-channel enable (DMACON AUDxEN & DMAEN)
- dmareq  in  4  channel DMA request
- dmas  in  4  channel restart request (reload pointer)
- reg_address_in  in  8  register address bits [8:1]
- data_in  in  16  bus write data
- strhor  out  1  horizontal strobe to channels
- dma  out  1  this block owns the current bus slot
- address_out  out  20  chip word address [20:1]
- reg_address_out  out  8  destination register [8:1] (AUDxDAT)

## Operation
- Register writes (when clk7_en): AUDxLCH at 9'h0A0+16n loads lc[n][20:16] <= data_in[4:0]; AUDxLCL at 9'h0A2+16n loads lc[n][15:1] <= data_in[15:1]. pt is not affected by lc writes.
- Sample: clk7_en & cck & hpos==STROBE_HPOS -> pend[n] <= dmareq[n] & dmaen[n]; rst[n] <= dmas[n]; strhor = 1 for that single clk7_en cycle, 0 otherwise.
- Slot n active when hpos==SLOT_BASE+2n & pend[n] & dmaen[n]: dma=1; address_out = rst[n] ? lc[n] : pt[n]; reg_address_out = 8'h55+8n (AUDxDAT).
- Slot end (clk7_en & cck during active slot): pt[n] <= (rst[n] ? lc[n] : pt[n]) + 1, 20-bit wrap FFFFF -> 00000; pend[n] <= 0; rst[n] <= 0.
- Inactive slot: dma=0, address_out=0, reg_address_out=8'hFF.
- dmaen[n] falling while pend[n]=1: pend[n], rst[n] cleared next clk7_en; slot unused, pt unchanged.
- LC write in same cycle as restart slot: bus address and pt update use old lc; new lc visible from next cycle.
- Per-channel state: lc (20b), pt (20b), pend, rst. No arbitration between channels: slots are disjoint by construction.

## Timing
- Reset: lc=0, pt=0, pend=0, rst=0; strhor=0, dma=0, address_out=0, reg_address_out=8'hFF.
- dma/address_out/reg_address_out combinational from hpos and registered state; valid for whole slot.
- Request latency: dmareq asserted before STROBE_HPOS is served in same line; asserted after it waits one line.
- pt update is registered: new value visible the clk7_en cycle after slot end.
- Reset asserted mid-slot: dma drops next clock; pt not updated.

## Structure
- Package agnus_audio_pkg: register offsets (AUDLCH, AUDLCL, AUDDAT base and 16-byte stride), channel count 4, default STROBE_HPOS/SLOT_BASE.
- Sub-module agnus_audio_ptr (instanced 4×): lc/pt/pend/rst for one channel, slot-hit input, address output. Top: strobe generation, slot decode, output mux.

## Test plan
- lc[0]=0x12340 (LCH=0x0001, LCL=0x2340... word address 0x091A0), dmareq[0]=dmas[0]=1 -> strhor at hpos 0x001, dma at hpos 0x00D, address_out=lc, reg_address_out=0x55; pt[0]=lc+1.
- Following line dmareq[0]=1, dmas=0 -> address_out = lc+1, pt = lc+2.
- All four channels requesting -> four dma pulses at 0x00D/0x00F/0x011/0x013, reg_address_out 0x55/0x5D/0x65/0x6D.
- pt[2]=0xFFFFF, non-restart request -> address_out=0xFFFFF, pt[2]=0x00000.
- dmaen[1] cleared between 0x001 and 0x00F -> no dma at 0x00F, pt[1] unchanged.
- LCL write at restart slot of channel 3 -> address_out=old lc, next restart uses new lc; reset mid-line -> all outputs return to reset values.
